mem_arbiter: RTL

Two-requester arbiter that shares one single-ported memory between the MIPS instruction-fetch path and the load/store path. Each cycle it grants at most one request, drives the memory port, and routes read data back to the owner a fixed RD_LATENCY cycles later. Conflicting requests are resolved round-robin, so neither side starves.

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the instruction-fetch port, the load/store port and the shared
//   single-ported memory port of mem_arbiter.
//
//   i_*  : fetch requester  (req/addr in, gnt/rvalid/rdata out of arbiter)
//   d_*  : data requester   (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   m_*  : memory port      (en/we/addr/wdata out of arbiter, rdata in)
//
//   slave  : arbiter view
//   master : requester + memory side view
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between the instruction-fetch path and
//   the load/store path. At most one request is granted per cycle (grant is
//   combinational, same cycle as req). Conflicts are resolved round-robin via
//   a one-bit priority flag. Read data is routed back to its owner exactly
//   RD_LATENCY cycles after the grant through a {valid, owner} shift pipeline.
//
// Parameters
//   ADDR_W, DATA_W : bus widths
//   RD_LATENCY     : memory read latency in cycles, 1..4
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (fetch, data and memory ports)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    // Priority flag: 0 = fetch won the last conflict, 1 = data won it.
    logic last_q, last_d;

    // Return pipeline, stage 0 is the push side, stage RD_LATENCY-1 the tail.
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0] own_pipe_q, own_pipe_d;

    logic              i_gnt, d_gnt;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              ret_vld, ret_own;
    logic              i_rvalid, d_rvalid;
    logic [DATA_W-1:0] i_rdata, d_rdata;

    // -------------------------------------------------------------------------
    // Arbitration: data wins a conflict unless it won the previous one.
    // Grants are gated by rst so nothing reaches memory during reset.
    // -------------------------------------------------------------------------
    always_comb begin
        d_gnt  = ~rst & bus.d_req & (~bus.i_req | ~last_q);
        i_gnt  = ~rst & bus.i_req & ~d_gnt;

        last_d = last_q;
        if (bus.i_req && bus.d_req && !rst) begin
            last_d = d_gnt;
        end
    end

    // -------------------------------------------------------------------------
    // Memory port mux. Fetch never writes and has no write data.
    // -------------------------------------------------------------------------
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_we    = d_gnt & bus.d_we;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_addr  = bus.d_addr;
            m_wdata = bus.d_wdata;
        end else if (i_gnt) begin
            m_addr  = bus.i_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Return tracking. Every cycle pushes one entry (a bubble on write/idle),
    // so the tail lines up with the memory's fixed read latency.
    // -------------------------------------------------------------------------
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        own_pipe_d    = own_pipe_q;
        vld_pipe_d[0] = m_en & ~m_we;
        own_pipe_d[0] = d_gnt;
        for (int k = 1; k < RD_LATENCY; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            own_pipe_d[k] = own_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= 1'b0;
            vld_pipe_q <= '0;
            own_pipe_q <= '0;
        end else begin
            last_q     <= last_d;
            vld_pipe_q <= vld_pipe_d;
            own_pipe_q <= own_pipe_d;
        end
    end

    // -------------------------------------------------------------------------
    // Tail routing; the unselected read data bus is held at zero.
    // -------------------------------------------------------------------------
    always_comb begin
        ret_vld  = vld_pipe_q[RD_LATENCY-1];
        ret_own  = own_pipe_q[RD_LATENCY-1];
        i_rvalid = ret_vld & ~ret_own;
        d_rvalid = ret_vld & ret_own;
        i_rdata  = i_rvalid ? bus.m_rdata : '0;
        d_rdata  = d_rvalid ? bus.m_rdata : '0;
    end

    assign bus.i_gnt    = i_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.m_en     = m_en;
    assign bus.m_we     = m_we;
    assign bus.m_addr   = m_addr;
    assign bus.m_wdata  = m_wdata;
    assign bus.i_rvalid = i_rvalid;
    assign bus.i_rdata  = i_rdata;
    assign bus.d_rvalid = d_rvalid;
    assign bus.d_rdata  = d_rdata;

endmodule
